// File: rtl/fft_stage_sequencer_if.sv
// Control bus shared by the FFT top level (start/done side) and the stage sequencer,
// which in turn broadcasts MAC phase, stage and strobes to the butterfly banks.
interface fft_stage_sequencer_if;
  logic       start;
  logic       hold;
  logic       abort;
  logic [2:0] count;
  logic [2:0] count_reg;
  logic       flag;
  logic [2:0] stage;
  logic [2:0] tw_shift;
  logic       in_we;
  logic       stage_we;
  logic       busy;
  logic       done;

  modport master (
    output start, hold, abort,
    input  count, count_reg, flag, stage, tw_shift, in_we, stage_we, busy, done
  );

  modport slave (
    input  start, hold, abort,
    output count, count_reg, flag, stage, tw_shift, in_we, stage_we, busy, done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Steps the radix-2 butterfly array through NUM_STAGES stages of CNT_MAX+1 MAC phases,
// producing input-capture, result-latch and inter-stage write strobes plus start/done handshake.
module fft_stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_MAX    = 5
) (
  input  logic                  clk_MAC,
  input  logic                  rst,
  fft_stage_sequencer_if.slave  bus
);

  localparam logic [2:0] CntLast   = 3'(CNT_MAX);
  localparam logic [2:0] StageLast = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    LATCH,
    DONE
  } state_e;

  state_e     state_q;
  logic [2:0] count_q;
  logic [2:0] countReg_q;
  logic [2:0] stage_q;
  logic       inWe_q;
  logic       flag_q;
  logic       stageWe_q;
  logic       busy_q;
  logic       done_q;

  // Strobes default low every cycle so each is a one-cycle pulse; abort overrides every state.
  always_ff @(posedge clk_MAC or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      countReg_q <= '0;
      stage_q    <= '0;
      inWe_q     <= 1'b0;
      flag_q     <= 1'b0;
      stageWe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      countReg_q <= count_q;
      inWe_q     <= 1'b0;
      flag_q     <= 1'b0;
      stageWe_q  <= 1'b0;
      done_q     <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        count_q <= '0;
        stage_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q <= LOAD;
              count_q <= '0;
              stage_q <= '0;
              inWe_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          LOAD: begin
            state_q <= MAC;
          end
          MAC: begin
            if (!bus.hold) begin
              if (count_q == CntLast) begin
                state_q   <= LATCH;
                count_q   <= '0;
                flag_q    <= 1'b1;
                stageWe_q <= 1'b1;
              end else begin
                count_q <= count_q + 3'd1;
              end
            end
          end
          LATCH: begin
            if (stage_q == StageLast) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= MAC;
              stage_q <= stage_q + 3'd1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            stage_q <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            count_q <= '0;
            stage_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.count_reg = countReg_q;
  assign bus.stage     = stage_q;
  assign bus.tw_shift  = StageLast - stage_q;
  assign bus.in_we     = inWe_q;
  assign bus.flag      = flag_q;
  assign bus.stage_we  = stageWe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: directed scenarios plus random start/hold/abort traffic,
// checked every cycle against a schedule-of-slots reference model.
module tb_fft_stage_sequencer;

  typedef enum {K_LOAD, K_MAC, K_LATCH, K_DONE} kind_e;
  typedef struct {
    kind_e kind;
    int    stg;
    int    cnt;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   useB = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: a transform is the ordered list of cycles it must produce.
  slot_t slots[$];
  int    slotIdx = 0;
  bit    active = 1'b0;
  int    prevCount = 0;
  int    ns = 5;
  int    cm = 5;
  int    eCount;
  int    eStage;
  bit    eInWe, eFlag, eStWe, eBusy, eDone;

  always #5 clk = ~clk;

  fft_stage_sequencer_if busA();
  fft_stage_sequencer_if busB();

  fft_stage_sequencer #(.NUM_STAGES(5), .CNT_MAX(5)) dutA (
    .clk_MAC (clk),
    .rst     (rst),
    .bus     (busA)
  );

  fft_stage_sequencer #(.NUM_STAGES(2), .CNT_MAX(3)) dutB (
    .clk_MAC (clk),
    .rst     (rst),
    .bus     (busB)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic buildRun();
    slots.delete();
    slots.push_back('{kind: K_LOAD, stg: 0, cnt: 0});
    for (int s = 0; s < ns; s++) begin
      for (int p = 0; p <= cm; p++) slots.push_back('{kind: K_MAC, stg: s, cnt: p});
      slots.push_back('{kind: K_LATCH, stg: s, cnt: 0});
    end
    slots.push_back('{kind: K_DONE, stg: ns - 1, cnt: 0});
  endtask

  task automatic computeExp();
    eCount = 0; eStage = 0;
    eInWe = 0; eFlag = 0; eStWe = 0; eBusy = 0; eDone = 0;
    if (active) begin
      eBusy  = 1;
      eStage = slots[slotIdx].stg;
      case (slots[slotIdx].kind)
        K_LOAD:  eInWe = 1;
        K_MAC:   eCount = slots[slotIdx].cnt;
        K_LATCH: begin eFlag = 1; eStWe = 1; end
        K_DONE:  eDone = 1;
        default: eBusy = 1;
      endcase
    end
  endtask

  task automatic modelStep(input bit s, input bit h, input bit a);
    computeExp();
    prevCount = eCount;
    if (a) begin
      active = 0;
    end else if (!active) begin
      if (s) begin
        buildRun();
        slotIdx = 0;
        active  = 1;
      end
    end else if (!(slots[slotIdx].kind == K_MAC && h)) begin
      slotIdx++;
      if (slotIdx >= slots.size()) active = 0;
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit obsDone();
    return useB ? busB.done : busA.done;
  endfunction

  task automatic checkOutput(input string tag);
    logic [2:0] oCount, oCountReg, oStage, oTw;
    logic       oInWe, oFlag, oStWe, oBusy, oDone;
    computeExp();
    if (useB) begin
      oCount = busB.count; oCountReg = busB.count_reg; oStage = busB.stage; oTw = busB.tw_shift;
      oInWe = busB.in_we; oFlag = busB.flag; oStWe = busB.stage_we; oBusy = busB.busy; oDone = busB.done;
    end else begin
      oCount = busA.count; oCountReg = busA.count_reg; oStage = busA.stage; oTw = busA.tw_shift;
      oInWe = busA.in_we; oFlag = busA.flag; oStWe = busA.stage_we; oBusy = busA.busy; oDone = busA.done;
    end
    cmp({tag, ".count"},     8'(oCount),    8'(eCount));
    cmp({tag, ".count_reg"}, 8'(oCountReg), 8'(prevCount));
    cmp({tag, ".stage"},     8'(oStage),    8'(eStage));
    cmp({tag, ".tw_shift"},  8'(oTw),       8'(ns - 1 - eStage));
    cmp({tag, ".in_we"},     8'(oInWe),     8'(eInWe));
    cmp({tag, ".flag"},      8'(oFlag),     8'(eFlag));
    cmp({tag, ".stage_we"},  8'(oStWe),     8'(eStWe));
    cmp({tag, ".busy"},      8'(oBusy),     8'(eBusy));
    cmp({tag, ".done"},      8'(oDone),     8'(eDone));
  endtask

  task automatic applyStimulus(input bit s, input bit h, input bit a, input string tag);
    busA.start = useB ? 1'b0 : s;
    busA.hold  = useB ? 1'b0 : h;
    busA.abort = useB ? 1'b0 : a;
    busB.start = useB ? s : 1'b0;
    busB.hold  = useB ? h : 1'b0;
    busB.abort = useB ? a : 1'b0;
    @(posedge clk);
    cyc++;
    modelStep(s, h, a);
    @(negedge clk);
    checkOutput(tag);
  endtask

  // Call n checks cycle n after the start edge; its inputs are driven during cycle n-1.
  task automatic measureRun(input int holdFrom, input int holdTo, input int abortAt,
                            input bit randStart, input string tag,
                            output int doneCyc, output int dones);
    bit s;
    doneCyc = -1;
    dones   = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, tag);
    for (int n = 2; n <= 60; n++) begin
      s = (randStart && n <= 38) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(s, (n >= holdFrom && n <= holdTo), (n == abortAt), tag);
      if (obsDone()) begin
        dones++;
        if (doneCyc < 0) doneCyc = n;
      end
    end
  endtask

  initial begin
    int doneCyc;
    int dones;
    busA.start = 0; busA.hold = 0; busA.abort = 0;
    busB.start = 0; busB.hold = 0; busB.abort = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, "idleHold");

    measureRun(0, 0, 0, 1'b0, "nominal", doneCyc, dones);
    cmp("nominal.doneCycle", 8'(doneCyc), 8'd37);
    cmp("nominal.doneCount", 8'(dones), 8'd1);

    measureRun(12, 14, 0, 1'b0, "hold", doneCyc, dones);
    cmp("hold.doneCycle", 8'(doneCyc), 8'd40);

    measureRun(0, 0, 28, 1'b0, "abort", doneCyc, dones);
    cmp("abort.doneCount", 8'(dones), 8'd0);
    measureRun(0, 0, 0, 1'b0, "afterAbort", doneCyc, dones);
    cmp("afterAbort.doneCycle", 8'(doneCyc), 8'd37);

    measureRun(0, 0, 0, 1'b1, "ignoredStart", doneCyc, dones);
    cmp("ignoredStart.doneCycle", 8'(doneCyc), 8'd37);
    cmp("ignoredStart.doneCount", 8'(dones), 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, "startAbortIdle");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, "startAbortIdle");

    applyStimulus(1'b1, 1'b0, 1'b0, "midReset");
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, "midReset");
    rst = 1'b1;
    #1;
    active = 0;
    prevCount = 0;
    checkOutput("midResetAsync");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetRelease");
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b0, "midResetAfter");

    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 63) == 0), "randomA");

    applyStimulus(1'b0, 1'b0, 1'b1, "switch");
    applyStimulus(1'b0, 1'b0, 1'b0, "switch");
    useB = 1'b1;
    ns = 2;
    cm = 3;
    active = 0;
    prevCount = 0;
    checkOutput("paramIdle");
    measureRun(0, 0, 0, 1'b0, "param", doneCyc, dones);
    cmp("param.doneCycle", 8'(doneCyc), 8'd12);
    cmp("param.doneCount", 8'(dones), 8'd1);
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 47) == 0), "randomB");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
